// File: rtl/uart_pkg.sv
// Shared UART constants and elaboration-time helpers, used by the bit-rate
// generator and by the TX/RX shift paths.
package uart_pkg;

    localparam int unsigned DIV_MIN   = 4;
    localparam int unsigned FRAME_LEN = 10;

    function automatic int unsigned default_div(input int unsigned clk_freq,
                                                input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_div_ctrl.sv
// Divisor register for the bit-rate generator: holds the active clocks-per-bit
// value and defers run-time rewrites to the next bit boundary.
module uart_div_ctrl
    import uart_pkg::*;
#(
    parameter int          DIV_W   = 16,
    parameter int unsigned RST_DIV = 5208
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             count_sig,
    input  logic             bit_end,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic [DIV_W-1:0] div_cur,
    output logic             div_pend,
    output logic             div_err
);

    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_nxt_q, div_nxt_d;
    logic             div_pend_q, div_pend_d;
    logic             div_err_q, div_err_d;
    logic             wr_ok;

    always_comb begin
        wr_ok      = div_wr && (div_in >= DIV_W'(DIV_MIN));
        div_err_d  = div_wr && !wr_ok;
        div_cur_d  = div_cur_q;
        div_nxt_d  = div_nxt_q;
        div_pend_d = div_pend_q;
        // Stopped or at a boundary: a write arriving now beats an older pending value.
        if (!count_sig || bit_end) begin
            if (wr_ok)           div_cur_d = div_in;
            else if (div_pend_q) div_cur_d = div_nxt_q;
            div_pend_d = 1'b0;
        end else if (wr_ok) begin
            div_nxt_d  = div_in;
            div_pend_d = 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            div_cur_q  <= DIV_W'(RST_DIV);
            div_nxt_q  <= DIV_W'(RST_DIV);
            div_pend_q <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            div_cur_q  <= div_cur_d;
            div_nxt_q  <= div_nxt_d;
            div_pend_q <= div_pend_d;
            div_err_q  <= div_err_d;
        end
    end

    assign div_cur  = div_cur_q;
    assign div_pend = div_pend_q;
    assign div_err  = div_err_q;

endmodule

// File: rtl/uart_bps_gen.sv
// Run-time programmable UART bit-rate generator: bit mid-point and end strobes,
// RX oversample tick, and bit position within the frame.
module uart_bps_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned DEFAULT_BAUD = 9600,
    parameter int          DIV_W        = 16,
    parameter int          OVS_LOG2     = 4,
    parameter int          FRAME_BITS   = FRAME_LEN
) (
    input  logic             sclk,
    input  logic             RSTn,
    input  logic             Count_Sig,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             BPS_CLK,
    output logic             bit_end,
    output logic             ovs_tick,
    output logic [3:0]       bit_idx,
    output logic             frame_done,
    output logic [DIV_W-1:0] div_cur,
    output logic             div_pend,
    output logic             div_err
);

    localparam int unsigned DEFAULT_DIV = default_div(CLK_FREQ, DEFAULT_BAUD);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ovs_cnt_q, ovs_cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             run_q;
    logic [DIV_W-1:0] last_cnt, mid_cnt, ovs_raw, ovs_div, ovs_last;
    logic             last_bit;

    uart_div_ctrl #(
        .DIV_W   (DIV_W),
        .RST_DIV (DEFAULT_DIV)
    ) u_div_ctrl (
        .sclk      (sclk),
        .rst_n     (RSTn),
        .count_sig (Count_Sig),
        .bit_end   (bit_end),
        .div_wr    (div_wr),
        .div_in    (div_in),
        .div_cur   (div_cur),
        .div_pend  (div_pend),
        .div_err   (div_err)
    );

    always_comb begin
        last_cnt   = div_cur - DIV_W'(1);
        mid_cnt    = (div_cur >> 1) - DIV_W'(1);
        ovs_raw    = div_cur >> OVS_LOG2;
        ovs_div    = (ovs_raw == '0) ? DIV_W'(1) : ovs_raw;
        ovs_last   = ovs_div - DIV_W'(1);
        last_bit   = (bit_idx_q == 4'(FRAME_BITS - 1));

        bit_end    = run_q && (cnt_q == last_cnt);
        BPS_CLK    = run_q && (cnt_q == mid_cnt);
        ovs_tick   = run_q && (ovs_cnt_q == ovs_last);
        frame_done = bit_end && last_bit;
        bit_idx    = bit_idx_q;

        cnt_d     = '0;
        ovs_cnt_d = '0;
        bit_idx_d = '0;
        if (Count_Sig) begin
            // >= rather than == so a stale count can never run past the divisor
            cnt_d     = (cnt_q >= last_cnt) ? '0 : cnt_q + DIV_W'(1);
            // Oversample phase restarts every bit so truncation error never accumulates.
            ovs_cnt_d = (bit_end || ovs_cnt_q >= ovs_last) ? '0 : ovs_cnt_q + DIV_W'(1);
            bit_idx_d = bit_idx_q;
            if (bit_end) bit_idx_d = last_bit ? 4'd0 : bit_idx_q + 4'd1;
        end
    end

    always_ff @(posedge sclk) begin
        if (!RSTn) begin
            cnt_q     <= '0;
            ovs_cnt_q <= '0;
            bit_idx_q <= '0;
            run_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ovs_cnt_q <= ovs_cnt_d;
            bit_idx_q <= bit_idx_d;
            run_q     <= Count_Sig;
        end
    end

endmodule

// File: tb/tb_uart_bps_gen.sv
// Self-checking bench for uart_bps_gen: cycle model of bit position and divisor
// rules compared every cycle, plus hand-computed timing expectations.
module tb_uart_bps_gen;

    logic        sclk = 1'b0;
    logic        RSTn = 1'b0;
    logic        Count_Sig = 1'b0;
    logic        div_wr = 1'b0;
    logic [15:0] div_in = 16'd0;
    logic        BPS_CLK, bit_end, ovs_tick, frame_done, div_pend, div_err;
    logic [3:0]  bit_idx;
    logic [15:0] div_cur;

    int n_vec = 0;
    int n_err = 0;
    int k;
    int bps1 = -1, bps2 = -1, be1 = -1, ovs1 = -1, ovs2 = -1, ovs_b1 = -1;
    int nbe = 0, nfd = 0, fd_at = -1;

    always #5 sclk = ~sclk;

    uart_bps_gen dut (
        .sclk       (sclk),
        .RSTn       (RSTn),
        .Count_Sig  (Count_Sig),
        .div_wr     (div_wr),
        .div_in     (div_in),
        .BPS_CLK    (BPS_CLK),
        .bit_end    (bit_end),
        .ovs_tick   (ovs_tick),
        .bit_idx    (bit_idx),
        .frame_done (frame_done),
        .div_cur    (div_cur),
        .div_pend   (div_pend),
        .div_err    (div_err)
    );

    // Model state: position within the current bit, bit number, divisor in use.
    typedef struct {
        int pos;
        int idx;
        int dv;
        int nxt;
        bit pend;
        bit run;
        bit err;
        bit ok;
    } mst_t;

    mst_t m;

    function automatic mst_t step(mst_t s, bit rstn, bit cs, bit wr, int din);
        mst_t n;
        bit   at_end;
        bit   good;
        n      = s;
        at_end = s.run && (s.pos == s.dv - 1);
        good   = wr && (din >= 4);
        if (!rstn) begin
            n.pos = 0; n.idx = 0; n.dv = 5208; n.nxt = 5208;
            n.pend = 0; n.run = 0; n.err = 0; n.ok = 1;
            return n;
        end
        n.err = wr && (din < 4);
        n.run = cs;
        if (!cs) begin
            n.pos = 0; n.idx = 0;
        end else if (at_end) begin
            n.pos = 0; n.idx = (s.idx + 1) % 10;
        end else begin
            n.pos = s.pos + 1;
        end
        if (!cs || at_end) begin
            if (good)        n.dv = din;
            else if (s.pend) n.dv = s.nxt;
            n.pend = 0;
        end else if (good) begin
            n.nxt = din; n.pend = 1;
        end
        return n;
    endfunction

    always @(posedge sclk) m <= step(m, RSTn, Count_Sig, div_wr, int'(div_in));

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 20) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic cyc();
        int ov;
        @(negedge sclk);
        if (m.ok) begin
            ov = m.dv / 16;
            if (ov == 0) ov = 1;
            chk("bps_clk",    int'(BPS_CLK),    int'(m.run && m.pos == m.dv / 2 - 1));
            chk("bit_end",    int'(bit_end),    int'(m.run && m.pos == m.dv - 1));
            chk("ovs_tick",   int'(ovs_tick),   int'(m.run && (m.pos % ov) == ov - 1));
            chk("frame_done", int'(frame_done), int'(m.run && m.pos == m.dv - 1 && m.idx == 9));
            chk("bit_idx",    int'(bit_idx),    m.idx);
            chk("div_cur",    int'(div_cur),    m.dv);
            chk("div_pend",   int'(div_pend),   int'(m.pend));
            chk("div_err",    int'(div_err),    int'(m.err));
        end
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_div_cur", int'(div_cur), 5208);
        chk("rst_bit_idx", int'(bit_idx), 0);
        chk("rst_pend",    int'(div_pend), 0);
        RSTn = 1'b1;
        cyc();

        // Default rate over one full frame
        Count_Sig = 1'b1;
        for (int c = 1; c <= 52080; c++) begin
            cyc();
            if (BPS_CLK) begin
                if (bps1 < 0) bps1 = c;
                else if (bps2 < 0) bps2 = c;
            end
            if (ovs_tick) begin
                if (ovs1 < 0) ovs1 = c;
                else if (ovs2 < 0) ovs2 = c;
                if (c > 5207 && ovs_b1 < 0) ovs_b1 = c;
            end
            if (bit_end) begin
                nbe++;
                if (be1 < 0) be1 = c;
            end
            if (frame_done) begin
                nfd++;
                fd_at = c;
            end
        end
        chk("first_bps",       bps1,   2603);
        chk("second_bps",      bps2,   7811);
        chk("first_bit_end",   be1,    5207);
        chk("first_ovs",       ovs1,   324);
        chk("second_ovs",      ovs2,   649);
        chk("ovs_realigned",   ovs_b1, 5532);
        chk("bit_end_count",   nbe,    10);
        chk("frame_count",     nfd,    1);
        chk("frame_done_at",   fd_at,  52079);
        chk("idx_after_frame", int'(bit_idx), 0);

        // Reset mid-frame with a write still pending
        repeat (2999) cyc();
        div_wr = 1'b1; div_in = 16'd100;
        cyc();
        div_wr = 1'b0;
        chk("pend_before_rst", int'(div_pend), 1);
        RSTn = 1'b0; Count_Sig = 1'b0;
        cyc();
        chk("rst_mid_div",  int'(div_cur), 5208);
        chk("rst_mid_idx",  int'(bit_idx), 0);
        chk("rst_mid_pend", int'(div_pend), 0);
        chk("rst_mid_puls", int'({BPS_CLK, bit_end, ovs_tick, frame_done}), 0);
        RSTn = 1'b1;
        cyc();

        // Mid-bit write is deferred to the bit boundary
        Count_Sig = 1'b1;
        repeat (1000) cyc();
        div_wr = 1'b1; div_in = 16'd100;
        cyc();
        div_wr = 1'b0;
        chk("mid_pend", int'(div_pend), 1);
        chk("mid_keep", int'(div_cur), 5208);
        k = 0;
        while (!bit_end && k < 6000) begin cyc(); k++; end
        chk("old_bit_len", k, 4206);
        cyc();
        chk("new_div",    int'(div_cur), 100);
        chk("pend_clear", int'(div_pend), 0);
        k = 0;
        while (!bit_end && k < 200) begin cyc(); k++; end
        chk("new_bit_len", k, 99);

        // Write landing on bit_end applies at that boundary
        div_wr = 1'b1; div_in = 16'd50;
        cyc();
        div_wr = 1'b0;
        chk("coinc_div",  int'(div_cur), 50);
        chk("coinc_pend", int'(div_pend), 0);
        k = 0;
        while (!bit_end && k < 200) begin cyc(); k++; end
        chk("coinc_bit_len", k, 49);
        cyc();

        // Rejected divisor
        div_wr = 1'b1; div_in = 16'd3;
        cyc();
        div_wr = 1'b0;
        chk("err_pulse", int'(div_err), 1);
        chk("err_keep",  int'(div_cur), 50);
        cyc();
        chk("err_once",  int'(div_err), 0);

        // Stopping while a write is pending applies it at once
        div_wr = 1'b1; div_in = 16'd200;
        cyc();
        div_wr = 1'b0;
        chk("stop_pend", int'(div_pend), 1);
        Count_Sig = 1'b0;
        cyc();
        chk("stop_div",  int'(div_cur), 200);
        chk("stop_pclr", int'(div_pend), 0);

        // Idle write then run at 115200 baud
        div_wr = 1'b1; div_in = 16'd434;
        cyc();
        div_wr = 1'b0;
        chk("idle_div",  int'(div_cur), 434);
        chk("idle_pend", int'(div_pend), 0);
        Count_Sig = 1'b1;
        bps1 = -1; be1 = -1;
        for (int c = 1; c <= 440; c++) begin
            cyc();
            if (BPS_CLK && bps1 < 0) bps1 = c;
            if (bit_end && be1 < 0) be1 = c;
        end
        chk("fast_bps",     bps1, 216);
        chk("fast_bit_end", be1,  433);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
